// File: rtl/mcp3008_scan_scheduler.sv
// MCP3008 scan scheduler: every SAMPLE_PERIOD cycles walks the enabled ADC channels
// in ascending order, one SPI command at a time, and forwards each result as a sample.
module mcp3008_scan_scheduler #(
  parameter int SAMPLE_PERIOD = 100000,
  parameter int TIMEOUT       = 4096,
  parameter bit SINGLE_ENDED  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [7:0]  chan_en,
  output logic        spi_axiiv,
  output logic [16:0] spi_axiid,
  input  logic        spi_axiready,
  input  logic        spi_axiov,
  input  logic [16:0] spi_axiod,
  output logic        sample_valid,
  output logic [2:0]  sample_chan,
  output logic [9:0]  sample_data,
  output logic        scan_done,
  output logic        overrun,
  output logic        timeout_err,
  output logic        busy
);

  localparam int CW = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESULT, NEXT} state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  period_cnt;
  logic [TW-1:0]  wait_cnt;
  logic [7:0]     scan_mask;
  logic [2:0]     chan;
  logic           pending;

  logic start_due, scan_start, issue_fire, result_hit, timed_out, scan_finish;
  logic unused_od;

  assign unused_od = ^spi_axiod[16:10];

  function automatic logic [2:0] first_chan(input logic [7:0] m);
    first_chan = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) first_chan = 3'(i);
    end
  endfunction

  assign start_due = run && (period_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    scan_start  = 1'b0;
    issue_fire  = 1'b0;
    result_hit  = 1'b0;
    timed_out   = 1'b0;
    scan_finish = 1'b0;
    case (state)
      IDLE: begin
        // An empty mask consumes the start but never leaves IDLE.
        if (run && (start_due || pending)) begin
          scan_start = 1'b1;
          if (chan_en != 8'd0) state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (spi_axiready) begin
          issue_fire = 1'b1;
          state_nx   = WAIT_RESULT;
        end
      end
      WAIT_RESULT: begin
        if (spi_axiov) begin
          result_hit = 1'b1;
          state_nx   = NEXT;
        end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
          timed_out = 1'b1;
          state_nx  = NEXT;
        end
      end
      NEXT: begin
        if (scan_mask != 8'd0) begin
          state_nx = ISSUE;
        end else begin
          scan_finish = 1'b1;
          state_nx    = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt <= '0;
    end else if (!run || (period_cnt == CW'(SAMPLE_PERIOD - 1))) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + CW'(1);
    end
  end

  // scan_mask holds the channels of this scan that have not been commanded yet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_mask <= 8'd0;
      chan      <= 3'd0;
      wait_cnt  <= '0;
    end else begin
      if (scan_start) begin
        scan_mask <= chan_en;
        chan      <= first_chan(chan_en);
      end
      if (issue_fire) begin
        scan_mask[chan] <= 1'b0;
        wait_cnt        <= '0;
      end else if (state == WAIT_RESULT) begin
        wait_cnt <= wait_cnt + TW'(1);
      end
      if (state == NEXT && scan_mask != 8'd0) chan <= first_chan(scan_mask);
    end
  end

  // Missed periods collapse into a single pending start; dropping run discards it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else if (!run) begin
      pending <= 1'b0;
    end else if (start_due && state != IDLE) begin
      pending <= 1'b1;
      overrun <= 1'b1;
    end else if (scan_start) begin
      pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_valid <= 1'b0;
      sample_chan  <= 3'd0;
      sample_data  <= 10'd0;
      scan_done    <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      sample_valid <= result_hit;
      scan_done    <= scan_finish;
      if (result_hit) begin
        sample_chan <= chan;
        sample_data <= spi_axiod[9:0];
      end
      if (timed_out) timeout_err <= 1'b1;
    end
  end

  assign spi_axiiv = issue_fire;
  assign spi_axiid = (state == ISSUE) ? {1'b0, 1'b1, SINGLE_ENDED, chan, 11'b0} : 17'd0;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mcp3008_scan_scheduler.sv
// Bench for mcp3008_scan_scheduler: two instances (long and short period) driven by
// a behavioural SPI controller; events are logged and compared with expected scans.
module tb_mcp3008_scan_scheduler;

  localparam int TO = 64;

  typedef enum int {EV_CMD, EV_SAMPLE, EV_DONE, EV_BUSY_RISE, EV_TO_RISE, EV_OV} kind_t;
  typedef struct {int inst; kind_t kind; int val; int cyc;} ev_t;

  ev_t ev_q[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        run [2];
  logic [7:0]  chan_en [2];
  logic        iv [2];
  logic [16:0] id [2];
  logic        ready [2];
  logic        ov [2];
  logic [16:0] od [2];
  logic        sv [2];
  logic [2:0]  sch [2];
  logic [9:0]  sdat [2];
  logic        done [2];
  logic        ovr [2];
  logic        toe [2];
  logic        busy [2];

  int lat [2];
  int withhold [2];
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mcp3008_scan_scheduler #(.SAMPLE_PERIOD(200), .TIMEOUT(TO), .SINGLE_ENDED(1'b1)) dut_a (
    .clk(clk), .rst(rst), .run(run[0]), .chan_en(chan_en[0]),
    .spi_axiiv(iv[0]), .spi_axiid(id[0]), .spi_axiready(ready[0]),
    .spi_axiov(ov[0]), .spi_axiod(od[0]),
    .sample_valid(sv[0]), .sample_chan(sch[0]), .sample_data(sdat[0]),
    .scan_done(done[0]), .overrun(ovr[0]), .timeout_err(toe[0]), .busy(busy[0])
  );

  mcp3008_scan_scheduler #(.SAMPLE_PERIOD(10), .TIMEOUT(TO), .SINGLE_ENDED(1'b1)) dut_b (
    .clk(clk), .rst(rst), .run(run[1]), .chan_en(chan_en[1]),
    .spi_axiiv(iv[1]), .spi_axiid(id[1]), .spi_axiready(ready[1]),
    .spi_axiov(ov[1]), .spi_axiod(od[1]),
    .sample_valid(sv[1]), .sample_chan(sch[1]), .sample_data(sdat[1]),
    .scan_done(done[1]), .overrun(ovr[1]), .timeout_err(toe[1]), .busy(busy[1])
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // SPI controller model: accepts a command when idle, answers 0x3A0+chan after lat cycles.
  int remain [2];
  bit outstanding [2];
  int mch [2];
  always @(posedge clk or posedge rst) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        ready[g] <= 1'b1;
        ov[g]    <= 1'b0;
        od[g]    <= 17'd0;
        outstanding[g] = 1'b0;
        remain[g]      = 0;
        mch[g]         = 0;
      end else begin
        ov[g] <= 1'b0;
        if (iv[g] && ready[g]) begin
          outstanding[g] = 1'b1;
          remain[g]      = lat[g];
          mch[g]         = int'(id[g][13:11]);
          ready[g]      <= 1'b0;
        end else if (outstanding[g]) begin
          if (remain[g] <= 1) begin
            outstanding[g] = 1'b0;
            ready[g]      <= 1'b1;
            if (mch[g] != withhold[g]) begin
              ov[g] <= 1'b1;
              od[g] <= 17'(32'h3A0 + mch[g]);
            end
          end else begin
            remain[g] = remain[g] - 1;
          end
        end
      end
    end
  end

  logic prev_busy [2];
  logic prev_to [2];
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        prev_busy[g] = 1'b0;
        prev_to[g]   = 1'b0;
      end else begin
        if (iv[g]) begin
          ev_q.push_back('{g, EV_CMD, int'(id[g]), cyc});
          checkOutput("iv_only_in_scan", 64'(busy[g]), 64'd1);
        end
        if (ov[g]) ev_q.push_back('{g, EV_OV, int'(od[g]), cyc});
        if (sv[g]) ev_q.push_back('{g, EV_SAMPLE, int'({sch[g], sdat[g]}), cyc});
        if (done[g]) begin
          ev_q.push_back('{g, EV_DONE, 0, cyc});
          checkOutput("busy_low_at_done", 64'(busy[g]), 64'd0);
        end
        if (busy[g] && !prev_busy[g]) ev_q.push_back('{g, EV_BUSY_RISE, 0, cyc});
        if (toe[g] && !prev_to[g]) ev_q.push_back('{g, EV_TO_RISE, 0, cyc});
        prev_busy[g] = busy[g];
        prev_to[g]   = toe[g];
      end
    end
  end

  function automatic int countKind(input int inst, input kind_t k);
    int n = 0;
    foreach (ev_q[i]) if (ev_q[i].inst == inst && ev_q[i].kind == k) n++;
    return n;
  endfunction

  function automatic int nthEv(input int inst, input kind_t k, input int n, input bit want_cyc);
    int seen = 0;
    foreach (ev_q[i]) begin
      if (ev_q[i].inst == inst && ev_q[i].kind == k) begin
        if (seen == n) return want_cyc ? ev_q[i].cyc : ev_q[i].val;
        seen++;
      end
    end
    return -1;
  endfunction

  function automatic logic [63:0] packOut(input int g);
    return 64'({iv[g], id[g], sv[g], sch[g], sdat[g], done[g], ovr[g], toe[g], busy[g]});
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int g, input logic r, input logic [7:0] m, input int l, input int wh);
    chan_en[g]  = m;
    lat[g]      = l;
    withhold[g] = wh;
    run[g]      = r;
  endtask

  task automatic waitCount(input int g, input kind_t k, input int target, input int budget, input string tag);
    int n = 0;
    while (countKind(g, k) < target && n < budget) begin
      tick();
      n++;
    end
    checkOutput({tag, "_reached"}, 64'(countKind(g, k) >= target), 64'd1);
  endtask

  task automatic waitIdle(input int g, input int budget, input string tag);
    int n = 0;
    while (busy[g] && n < budget) begin
      tick();
      n++;
    end
    checkOutput({tag, "_idle"}, 64'(busy[g]), 64'd0);
  endtask

  // Reference: a scan of mask m issues every enabled channel in ascending order and
  // returns 0x3A0+chan for each, except a withheld channel which yields no sample.
  task automatic checkScan(input int g, input logic [7:0] m, input int nscans, input int skip, input string tag);
    int kc = 0;
    int ks = 0;
    for (int s = 0; s < nscans; s++) begin
      for (int ch = 0; ch < 8; ch++) begin
        if (m[ch]) begin
          checkOutput($sformatf("%s_cmd%0d", tag, kc), 64'(nthEv(g, EV_CMD, kc, 1'b0)),
                      64'((1 << 15) | (1 << 14) | (ch << 11)));
          kc++;
          if (ch != skip) begin
            checkOutput($sformatf("%s_smp%0d", tag, ks), 64'(nthEv(g, EV_SAMPLE, ks, 1'b0)),
                        64'((ch << 10) | (32'h3A0 + ch)));
            ks++;
          end
        end
      end
    end
    checkOutput({tag, "_ncmd"}, 64'(countKind(g, EV_CMD)), 64'(kc));
    checkOutput({tag, "_nsmp"}, 64'(countKind(g, EV_SAMPLE)), 64'(ks));
    checkOutput({tag, "_ndone"}, 64'(countKind(g, EV_DONE)), 64'((m != 8'd0) ? nscans : 0));
  endtask

  logic [7:0] rmask;
  int rlat;
  int t0;

  initial begin
    rst = 1'b1;
    for (int g = 0; g < 2; g++) applyStimulus(g, 1'b0, 8'h00, 4, 8);
    repeat (3) tick();
    checkOutput("reset_outs_a", packOut(0), 64'd0);
    checkOutput("reset_outs_b", packOut(1), 64'd0);
    rst = 1'b0;
    tick();

    $display("[TB] periodic scan, chan_en=05");
    ev_q.delete();
    applyStimulus(0, 1'b1, 8'h05, 4, 8);
    repeat (590) tick();
    run[0] = 1'b0;
    waitIdle(0, 100, "s1");
    checkScan(0, 8'h05, 3, 8, "s1");
    checkOutput("s1_period0", 64'(nthEv(0, EV_DONE, 1, 1'b1) - nthEv(0, EV_DONE, 0, 1'b1)), 64'd200);
    checkOutput("s1_period1", 64'(nthEv(0, EV_DONE, 2, 1'b1) - nthEv(0, EV_DONE, 1, 1'b1)), 64'd200);
    checkOutput("s1_latency", 64'(nthEv(0, EV_SAMPLE, 0, 1'b1) - nthEv(0, EV_OV, 0, 1'b1)), 64'd1);

    $display("[TB] empty mask");
    ev_q.delete();
    applyStimulus(0, 1'b1, 8'h00, 4, 8);
    repeat (450) tick();
    run[0] = 1'b0;
    checkScan(0, 8'h00, 1, 8, "empty");
    checkOutput("empty_busy_rises", 64'(countKind(0, EV_BUSY_RISE)), 64'd0);

    $display("[TB] randomized masks and latencies");
    for (int r = 0; r < 4; r++) begin
      rmask = 8'($urandom);
      rlat  = int'($urandom_range(1, 15));
      tick();
      ev_q.delete();
      applyStimulus(0, 1'b1, rmask, rlat, 8);
      repeat (150) tick();
      run[0] = 1'b0;
      waitIdle(0, 300, $sformatf("rnd%0d", r));
      checkScan(0, rmask, 1, 8, $sformatf("rnd%0d", r));
    end
    checkOutput("no_overrun_a", 64'(ovr[0]), 64'd0);

    $display("[TB] run dropped mid-scan");
    tick();
    ev_q.delete();
    applyStimulus(0, 1'b1, 8'h0F, 10, 8);
    waitCount(0, EV_CMD, 2, 100, "drop_cmd");
    run[0] = 1'b0;
    waitCount(0, EV_DONE, 1, 300, "drop_done");
    repeat (300) tick();
    checkScan(0, 8'h0F, 1, 8, "drop");
    checkOutput("drop_busy_rises", 64'(countKind(0, EV_BUSY_RISE)), 64'd1);

    $display("[TB] conversion timeout on CH1");
    ev_q.delete();
    applyStimulus(0, 1'b1, 8'h03, 3, 1);
    waitCount(0, EV_DONE, 1, 300, "tmo_done");
    run[0] = 1'b0;
    withhold[0] = 8;
    checkScan(0, 8'h03, 1, 1, "tmo");
    checkOutput("tmo_flag", 64'(toe[0]), 64'd1);
    // Issue cycle, then TIMEOUT cycles of waiting, then the flag registers.
    checkOutput("tmo_delay", 64'(nthEv(0, EV_TO_RISE, 0, 1'b1) - nthEv(0, EV_CMD, 1, 1'b1)), 64'(TO + 1));
    waitIdle(0, 50, "tmo");

    $display("[TB] reset during WAIT_RESULT");
    tick();
    ev_q.delete();
    applyStimulus(0, 1'b1, 8'h0F, 30, 8);
    waitCount(0, EV_CMD, 2, 200, "rst_cmd");
    repeat (5) tick();
    #1 rst = 1'b1;
    #1 checkOutput("rst_async_outs", packOut(0), 64'd0);
    tick();
    tick();
    ev_q.delete();
    rst = 1'b0;
    t0 = cyc;
    waitCount(0, EV_CMD, 1, 20, "restart");
    checkOutput("restart_cmd", 64'(nthEv(0, EV_CMD, 0, 1'b0)), 64'h0C000);
    checkOutput("restart_cycle", 64'(nthEv(0, EV_CMD, 0, 1'b1) - t0), 64'd1);
    run[0] = 1'b0;
    waitIdle(0, 400, "restart");

    $display("[TB] overrun, short period, all channels");
    ev_q.delete();
    applyStimulus(1, 1'b1, 8'hFF, 20, 8);
    waitCount(1, EV_DONE, 3, 1500, "ovr_done");
    run[1] = 1'b0;
    waitIdle(1, 300, "ovr");
    checkScan(1, 8'hFF, 3, 8, "ovr");
    checkOutput("ovr_flag", 64'(ovr[1]), 64'd1);
    checkOutput("ovr_b2b_1", 64'(nthEv(1, EV_BUSY_RISE, 1, 1'b1) - nthEv(1, EV_DONE, 0, 1'b1)), 64'd1);
    checkOutput("ovr_b2b_2", 64'(nthEv(1, EV_BUSY_RISE, 2, 1'b1) - nthEv(1, EV_DONE, 1, 1'b1)), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
